// File: rtl/dma_pkg.sv
// Shared definitions for the UART DMA path.
// Holds the sequencer state encoding, the host address width and cherry-float
// width, and the cherry-float to fp16 truncation that the writer applies.
package dma_pkg;

    localparam int HOST_AW = 7;
    localparam int CF_W    = 18;

    // Sequencer states; explicit encodings keep waveforms and older tools consistent.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_CAP  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } dma_seq_state_t;

    // Cherry float -> fp16: drop the two lowest mantissa bits.
    function automatic logic [CF_W-3:0] fp16(input logic [CF_W-1:0] cf);
        return cf[CF_W-1:2];
    endfunction

endpackage

// File: rtl/dma_uart_sequencer.sv
// Block-transfer feeder for the single-float UART DMA writer.
// Accepts one command (host base, SRAM base, length), reads each cherry float
// from SRAM and hands it to the writer one word at a time, pacing each word on
// the writer's busy flag, and pulses done when the block has been sent.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_host_addr/sram_addr/len  command fields; len 0 is an empty transfer
//   sram_rd_en/addr/data         SRAM read port, data valid one cycle after en
//   dma_we/dat_w/dat_addr/busy   writer interface
//   active, done                 transfer in progress / end-of-transfer pulse
module dma_uart_sequencer
    import dma_pkg::*;
#(
    parameter int HOST_AW = 7,
    parameter int SRAM_AW = 10,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [HOST_AW-1:0] cmd_host_addr,
    input  logic [SRAM_AW-1:0] cmd_sram_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               sram_rd_en,
    output logic [SRAM_AW-1:0] sram_rd_addr,
    input  logic [CF_W-1:0]    sram_rd_data,
    output logic               dma_we,
    output logic [CF_W-1:0]    dma_dat_w,
    output logic [HOST_AW-1:0] dma_dat_addr,
    input  logic               dma_busy,
    output logic               active,
    output logic               done
);

    dma_seq_state_t     state_q, state_d;
    logic [HOST_AW-1:0] host_cnt_q, host_cnt_d;
    logic [SRAM_AW-1:0] sram_cnt_q, sram_cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;

    logic               sram_rd_en_q;
    logic [SRAM_AW-1:0] sram_rd_addr_q;
    logic               dma_we_q;
    logic [CF_W-1:0]    dma_dat_w_q;
    logic [HOST_AW-1:0] dma_dat_addr_q;
    logic               active_q;
    logic               done_q;

    // Next-state and address/length counter update.
    always_comb begin
        state_d    = state_q;
        host_cnt_d = host_cnt_q;
        sram_cnt_d = sram_cnt_q;
        rem_d      = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    host_cnt_d = cmd_host_addr;
                    sram_cnt_d = cmd_sram_addr;
                    rem_d      = cmd_len;
                    state_d    = (cmd_len == '0) ? ST_DONE : ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT_HI;
            // Busy only rises after the writer has seen we; a low busy here means "not started yet".
            ST_WAIT_HI: begin
                if (dma_busy) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (!dma_busy) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            // Address counters wrap naturally at their widths.
            ST_NEXT: begin
                host_cnt_d = host_cnt_q + {{(HOST_AW-1){1'b0}}, 1'b1};
                sram_cnt_d = sram_cnt_q + {{(SRAM_AW-1){1'b0}}, 1'b1};
                rem_d      = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
                state_d    = (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the
    // next state so each one is valid during the state that owns it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            host_cnt_q     <= '0;
            sram_cnt_q     <= '0;
            rem_q          <= '0;
            sram_rd_en_q   <= 1'b0;
            sram_rd_addr_q <= '0;
            dma_we_q       <= 1'b0;
            dma_dat_w_q    <= '0;
            dma_dat_addr_q <= '0;
            active_q       <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            host_cnt_q   <= host_cnt_d;
            sram_cnt_q   <= sram_cnt_d;
            rem_q        <= rem_d;
            sram_rd_en_q <= (state_d == ST_RD_REQ);
            if (state_d == ST_RD_REQ) begin
                sram_rd_addr_q <= sram_cnt_d;
            end
            // SRAM data is valid during RD_CAP; the word then stays put until the next capture.
            if (state_q == ST_RD_CAP) begin
                dma_dat_w_q    <= sram_rd_data;
                dma_dat_addr_q <= host_cnt_q;
            end
            dma_we_q <= (state_d == ST_ISSUE);
            done_q   <= (state_d == ST_DONE);
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign sram_rd_en   = sram_rd_en_q;
    assign sram_rd_addr = sram_rd_addr_q;
    assign dma_we       = dma_we_q;
    assign dma_dat_w    = dma_dat_w_q;
    assign dma_dat_addr = dma_dat_addr_q;
    assign active       = active_q;
    assign done         = done_q;

endmodule

// File: tb/tb_dma_uart_sequencer.sv
// Self-checking bench for dma_uart_sequencer: SRAM model returning {8'hA5, addr},
// a writer model driving busy, a table of block transfers plus hand-written
// sequences for the empty transfer and reset mid-transfer.
module tb_dma_uart_sequencer;

    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_host_addr;
    logic [9:0]  cmd_sram_addr;
    logic [7:0]  cmd_len;
    logic        sram_rd_en;
    logic [9:0]  sram_rd_addr;
    logic [17:0] sram_rd_data = 18'd0;
    logic        dma_we;
    logic [17:0] dma_dat_w;
    logic [6:0]  dma_dat_addr;
    logic        dma_busy = 1'b0;
    logic        active;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    dma_uart_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_host_addr(cmd_host_addr),
        .cmd_sram_addr(cmd_sram_addr),
        .cmd_len      (cmd_len),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .dma_we       (dma_we),
        .dma_dat_w    (dma_dat_w),
        .dma_dat_addr (dma_dat_addr),
        .dma_busy     (dma_busy),
        .active       (active),
        .done         (done)
    );

    always #5 clk = ~clk;

    // SRAM: word at address a holds {8'hA5, a}, one-cycle read latency.
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= {8'hA5, sram_rd_addr};
    end

    // Writer: busy rises extra_lo cycles after the normal one-cycle delay, stays high busy_len cycles.
    int   busy_len = 2;
    int   extra_lo = 0;
    int   wlen = 0;
    int   wdly = 0;
    logic wpend = 1'b0;
    always @(posedge clk) begin
        if (dma_we) begin
            if (extra_lo == 0) begin
                dma_busy <= 1'b1;
                wlen     <= busy_len;
            end else begin
                wpend <= 1'b1;
                wdly  <= extra_lo;
            end
        end else if (wpend) begin
            if (wdly == 1) begin
                wpend    <= 1'b0;
                dma_busy <= 1'b1;
                wlen     <= busy_len;
            end else begin
                wdly <= wdly - 1;
            end
        end else if (dma_busy) begin
            if (wlen <= 1) dma_busy <= 1'b0;
            else wlen <= wlen - 1;
        end
    end

    // Monitor, sampled on the falling edge.
    logic [6:0]  wr_addr_q[$];
    logic [17:0] wr_data_q[$];
    int rd_cnt = 0;
    int done_cnt = 0;
    int we_busy = 0;
    always @(negedge clk) begin
        if (dma_we) begin
            wr_addr_q.push_back(dma_dat_addr);
            wr_data_q.push_back(dma_dat_w);
            if (dma_busy) we_busy++;
        end
        if (sram_rd_en) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  host;
        logic [9:0]  sram;
        logic [7:0]  len;
        int          bl;
        int          ex;
        bit          mid;
        int          exp_cyc;
        logic [6:0]  exp_last_addr;
        logic [17:0] exp_last_data;
    } vec_t;

    vec_t tbl[5];

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        we_busy  = 0;
    endtask

    task automatic wait_writer_idle();
        int w = 0;
        while (dma_busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("writer_idle", {31'd0, dma_busy}, 32'd0);
    endtask

    task automatic run_vector(input vec_t v);
        int cyc;
        logic [6:0] ea;
        logic [9:0] es;
        wait_writer_idle();
        busy_len = v.bl;
        extra_lo = v.ex;
        @(negedge clk);
        clear_mon();
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid     = 1'b1;
        cmd_host_addr = v.host;
        cmd_sram_addr = v.sram;
        cmd_len       = v.len;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        chk("active_after_accept", {31'd0, active}, 32'd1);
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (v.mid && cyc == 6) begin
                chk("cmd_ready_midxfer", {31'd0, cmd_ready}, 32'd0);
                cmd_valid     = 1'b1;
                cmd_host_addr = 7'h70;
                cmd_sram_addr = 10'h300;
                cmd_len       = 8'd5;
            end else if (v.mid && cyc == 7) begin
                cmd_valid = 1'b0;
            end
        end
        chk("done_latency", cyc, v.exp_cyc);
        chk("active_at_done", {31'd0, active}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("active_after_done", {31'd0, active}, 32'd0);
        chk("cmd_ready_after_done", {31'd0, cmd_ready}, 32'd1);
        chk("done_count", done_cnt, 32'd1);
        chk("sram_read_count", rd_cnt, {24'd0, v.len});
        chk("write_count", wr_addr_q.size(), {24'd0, v.len});
        chk("we_while_busy", we_busy, 32'd0);
        for (int i = 0; i < int'(v.len) && i < wr_addr_q.size(); i++) begin
            ea = v.host + 7'(i);
            es = v.sram + 10'(i);
            chk("write_addr", {25'd0, wr_addr_q[i]}, {25'd0, ea});
            chk("write_data", {14'd0, wr_data_q[i]}, {14'd0, 8'hA5, es});
        end
        if (wr_addr_q.size() != 0) begin
            chk("last_addr", {25'd0, wr_addr_q[wr_addr_q.size()-1]}, {25'd0, v.exp_last_addr});
            chk("last_data", {14'd0, wr_data_q[wr_data_q.size()-1]}, {14'd0, v.exp_last_data});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_sram_rd_en"}, {31'd0, sram_rd_en}, 32'd0);
        chk({tag, "_sram_rd_addr"}, {22'd0, sram_rd_addr}, 32'd0);
        chk({tag, "_dma_we"}, {31'd0, dma_we}, 32'd0);
        chk({tag, "_dma_dat_w"}, {14'd0, dma_dat_w}, 32'd0);
        chk({tag, "_dma_dat_addr"}, {25'd0, dma_dat_addr}, 32'd0);
        chk({tag, "_active"}, {31'd0, active}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int nwe;
        int w;
        // host, sram, len, busy cycles, extra low cycles, mid-transfer cmd, DONE cycle, last write
        tbl[0] = '{7'h10, 10'h020, 8'd3, 4, 0, 1'b0, 28, 7'h12, 18'h29422};
        tbl[1] = '{7'h7F, 10'h3FF, 8'd2, 2, 0, 1'b0, 15, 7'h00, 18'h29400};
        tbl[2] = '{7'h05, 10'h100, 8'd2, 3, 3, 1'b1, 23, 7'h06, 18'h29501};
        tbl[3] = '{7'h40, 10'h0F0, 8'd1, 1, 0, 1'b0, 7,  7'h40, 18'h294F0};
        tbl[4] = '{7'h33, 10'h044, 8'd2, 2, 0, 1'b0, 15, 7'h34, 18'h29445};

        resetn        = 1'b0;
        cmd_valid     = 1'b0;
        cmd_host_addr = 7'h00;
        cmd_sram_addr = 10'h000;
        cmd_len       = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;

        for (int k = 0; k < 4; k++) run_vector(tbl[k]);

        // Empty transfer: DONE directly after accept, no reads, no writes.
        wait_writer_idle();
        @(negedge clk);
        clear_mon();
        cmd_valid     = 1'b1;
        cmd_host_addr = 7'h11;
        cmd_sram_addr = 10'h055;
        cmd_len       = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_active", {31'd0, active}, 32'd1);
        chk("len0_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("len0_done_drop", {31'd0, done}, 32'd0);
        chk("len0_active_drop", {31'd0, active}, 32'd0);
        chk("len0_reads", rd_cnt, 32'd0);
        chk("len0_writes", wr_addr_q.size(), 32'd0);
        chk("len0_done_count", done_cnt, 32'd1);

        // Reset while word 2 of 4 is in WAIT_LO.
        busy_len = 6;
        extra_lo = 0;
        @(negedge clk);
        clear_mon();
        cmd_valid     = 1'b1;
        cmd_host_addr = 7'h20;
        cmd_sram_addr = 10'h200;
        cmd_len       = 8'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        nwe = 0;
        w   = 0;
        while (nwe < 2 && w < LIMIT) begin
            if (dma_we) nwe++;
            if (nwe < 2) begin
                @(negedge clk);
                w++;
            end
        end
        chk("rst_reached_word2", nwe, 32'd2);
        repeat (2) @(negedge clk);
        chk("rst_writer_busy", {31'd0, dma_busy}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt, 32'd0);
        chk("midrst_writes", wr_addr_q.size(), 32'd2);

        run_vector(tbl[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
